dist_metric: RTL

- Upstream neighbour of the survivor-path stage `path` in turbo_decode; produces the 14 squared-Euclidean branch metrics that `path` consumes on v_1..v_14.
- For one received soft sample (I/Q), computes d_n = (rx_i − REF_I[n])² + (rx_q − REF_Q[n])² for n = 0..13.
- One shared subtract/square/add datapath is time-multiplexed over a 2-stage pipeline, at one candidate per cycle.
- Results are held in 14 output registers; a one-cycle done pulse tells `path` when to sample them.

---
 rtl/turbo_pkg.sv | 38 +++
 rtl/dist_metric_pe.sv | 69 ++++++
 rtl/dist_metric.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo_decode branch-metric front end.
//   N_CAND       : number of candidate constellation points (one metric each)
//   W_IN         : signed width of received and reference coordinates
//   W_MET        : unsigned width of each squared-Euclidean metric
//   REF_I/REF_Q  : candidate point coordinates, index 0..N_CAND-1
//   state_t      : sequencing FSM encoding used by dist_metric
package turbo_pkg;

    localparam int N_CAND = 14;
    localparam int W_IN   = 14;
    localparam int W_MET  = 30;
    localparam int W_IDX  = 4;

    // Entry 0 and entry 1 sit at opposite corners of the input range so the
    // worst-case distance (2 * 16383^2) is reachable from a legal rx sample.
    localparam logic signed [W_IN-1:0] REF_I [0:N_CAND-1] = '{
        14'sd8191,  14'sh2000,  14'sd4096,  14'sd0,
        -14'sd4096, 14'sd0,     14'sd1000,  14'sd2896,
        -14'sd2896, -14'sd2896, 14'sd2896,  14'sd6000,
        -14'sd5000, 14'sd123
    };

    localparam logic signed [W_IN-1:0] REF_Q [0:N_CAND-1] = '{
        14'sd8191,  14'sh2000,  14'sd0,     14'sd4096,
        14'sd0,     -14'sd4096, -14'sd2000, 14'sd2896,
        14'sd2896,  -14'sd2896, -14'sd2896, -14'sd7000,
        14'sd3000,  -14'sd456
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(N_CAND - 1);

endpackage

// File: rtl/dist_metric_pe.sv
// sq_dist_pe: shared subtract -> square-and-add datapath.
// Stage 1 registers the signed coordinate differences against the candidate
// selected by idx_in; the squares and their sum are formed combinationally
// from those registers so the caller's register bank acts as stage 2.
//   clk, rst     : clock, synchronous active-high reset
//   issue        : launch candidate idx_in into stage 1 this edge
//   idx_in       : candidate index to evaluate
//   rx_i, rx_q   : latched received sample (two's complement)
//   valid        : stage 1 holds a live candidate; metric is meaningful
//   idx          : candidate index travelling with the stage-1 data
//   metric       : di^2 + dq^2 for that candidate
module sq_dist_pe
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [W_IDX-1:0] idx_in,
    input  logic [W_IN-1:0]  rx_i,
    input  logic [W_IN-1:0]  rx_q,
    output logic             valid,
    output logic [W_IDX-1:0] idx,
    output logic [W_MET-1:0] metric
);

    localparam int W_DIF = W_IN + 1;
    localparam int W_SQ  = 2 * W_DIF;

    logic [W_DIF-1:0] di;
    logic [W_DIF-1:0] dq;

    logic [W_IN-1:0] ref_i_sel;
    logic [W_IN-1:0] ref_q_sel;

    assign ref_i_sel = REF_I[idx_in];
    assign ref_q_sel = REF_Q[idx_in];

    // Operands sign-extended by one bit so the difference never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            idx   <= '0;
            di    <= '0;
            dq    <= '0;
        end else begin
            valid <= issue;
            if (issue) begin
                idx <= idx_in;
                di  <= {rx_i[W_IN-1], rx_i} - {ref_i_sel[W_IN-1], ref_i_sel};
                dq  <= {rx_q[W_IN-1], rx_q} - {ref_q_sel[W_IN-1], ref_q_sel};
            end
        end
    end

    logic signed [W_SQ-1:0] di_ext;
    logic signed [W_SQ-1:0] dq_ext;
    logic signed [W_SQ-1:0] sq_i;
    logic signed [W_SQ-1:0] sq_q;
    logic signed [W_SQ-1:0] sum;

    assign di_ext = {{W_DIF{di[W_DIF-1]}}, di};
    assign dq_ext = {{W_DIF{dq[W_DIF-1]}}, dq};
    assign sq_i   = di_ext * di_ext;
    assign sq_q   = dq_ext * dq_ext;
    // Largest sum is 2*16383^2 < 2^29, so the add cannot carry out of W_MET.
    assign sum    = sq_i + sq_q;
    assign metric = W_MET'(sum);

endmodule

// File: rtl/dist_metric.sv
// dist_metric: computes the 14 squared-Euclidean branch metrics for one
// received I/Q sample, one candidate per cycle through sq_dist_pe, and
// presents them on v_1..v_14 with a one-cycle done strobe.
//   clk, rst     : clock, synchronous active-high reset
//   start        : compute metrics for rx_i/rx_q (ignored while busy)
//   rx_i, rx_q   : received sample, two's complement, latched at start
//   busy         : computation in flight
//   done         : one-cycle pulse, v_1..v_14 complete and consistent
//   v_1..v_14    : metric for candidate n-1
//
// state | meaning
// IDLE  | waiting for start; outputs hold last results
// RUN   | issuing candidates 0..13 into the datapath, one per cycle
// DRAIN | last candidate still in the pipeline; leave once it has landed
module dist_metric
    import turbo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_IN-1:0]  rx_i,
    input  logic [W_IN-1:0]  rx_q,
    output logic             busy,
    output logic             done,
    output logic [W_MET-1:0] v_1,
    output logic [W_MET-1:0] v_2,
    output logic [W_MET-1:0] v_3,
    output logic [W_MET-1:0] v_4,
    output logic [W_MET-1:0] v_5,
    output logic [W_MET-1:0] v_6,
    output logic [W_MET-1:0] v_7,
    output logic [W_MET-1:0] v_8,
    output logic [W_MET-1:0] v_9,
    output logic [W_MET-1:0] v_10,
    output logic [W_MET-1:0] v_11,
    output logic [W_MET-1:0] v_12,
    output logic [W_MET-1:0] v_13,
    output logic [W_MET-1:0] v_14
);

    state_t state;
    state_t state_nxt;

    logic [W_IN-1:0]  rx_i_lat;
    logic [W_IN-1:0]  rx_q_lat;
    logic [W_IDX-1:0] idx_cnt;
    logic             load;
    logic             issue;
    logic             done_nxt;

    logic             pe_valid;
    logic [W_IDX-1:0] pe_idx;
    logic [W_MET-1:0] pe_metric;

    logic [W_MET-1:0] bank [0:N_CAND-1];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (idx_cnt == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 1 empties one edge after the last issue; by then the
                // final metric has been written into the bank.
                if (!pe_valid) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            idx_cnt  <= '0;
            rx_i_lat <= '0;
            rx_q_lat <= '0;
            for (int i = 0; i < N_CAND; i++) begin
                bank[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= done_nxt;
            if (load) begin
                rx_i_lat <= rx_i;
                rx_q_lat <= rx_q;
                idx_cnt  <= '0;
            end else if (issue) begin
                idx_cnt  <= idx_cnt + 1'b1;
            end
            if (pe_valid) begin
                bank[pe_idx] <= pe_metric;
            end
        end
    end

    sq_dist_pe u_pe (
        .clk    (clk),
        .rst    (rst),
        .issue  (issue),
        .idx_in (idx_cnt),
        .rx_i   (rx_i_lat),
        .rx_q   (rx_q_lat),
        .valid  (pe_valid),
        .idx    (pe_idx),
        .metric (pe_metric)
    );

    assign v_1  = bank[0];
    assign v_2  = bank[1];
    assign v_3  = bank[2];
    assign v_4  = bank[3];
    assign v_5  = bank[4];
    assign v_6  = bank[5];
    assign v_7  = bank[6];
    assign v_8  = bank[7];
    assign v_9  = bank[8];
    assign v_10 = bank[9];
    assign v_11 = bank[10];
    assign v_12 = bank[11];
    assign v_13 = bank[12];
    assign v_14 = bank[13];

endmodule
